// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - multi-cycle data-memory responder with wait states, lane masking and load extension
//
// Target side of the CPU data-memory interface. One access is accepted per
// handshake (req while ready), held for WAIT_CYCLES wait states, then answered
// with a one-cycle ack carrying DataOut and err.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      request valid, sampled while ready=1
//   DMWr     store type: 00 none, 01 sw, 10 sh, 11 sb
//   DMRe     load type: 000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu
//   Addr     byte address
//   DataIn   store data (sh: [15:0], sb: [7:0])
//   ready    idle, a request can be accepted this cycle
//   ack      one-cycle completion pulse
//   DataOut  extended load result, held until the next ack
//   err      access rejected, valid with ack

module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  DMWr,
    input  logic [2:0]  DMRe,
    input  logic [31:0] Addr,
    input  logic [31:0] DataIn,
    output logic        ready,
    output logic        ack,
    output logic [31:0] DataOut,
    output logic        err
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [33:0] SPAN     = 34'(DEPTH_WORDS) * 34'd4;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic [1:0]  cap_wr;
    logic [2:0]  cap_re;
    logic [31:0] cap_addr;
    logic [31:0] cap_din;

    logic [31:0] mem [DEPTH_WORDS];

    // Access currently being evaluated. With zero wait states the edge that
    // accepts the request is also the edge entering RESP, so the live inputs
    // must be used there; otherwise the captured copy is used.
    logic [1:0]  a_wr;
    logic [2:0]  a_re;
    logic [31:0] a_addr;
    logic [31:0] a_din;

    always_comb begin
        if (state == IDLE) begin
            a_wr   = DMWr;
            a_re   = DMRe;
            a_addr = Addr;
            a_din  = DataIn;
        end else begin
            a_wr   = cap_wr;
            a_re   = cap_re;
            a_addr = cap_addr;
            a_din  = cap_din;
        end
    end

    // Decode and error classification
    logic [33:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             is_word;
    logic             is_half;
    logic             out_of_range;
    logic             acc_err;

    always_comb begin
        offset       = {2'b00, a_addr} - {2'b00, BASE_ADDR};
        idx          = offset[IDX_W+1:2];
        is_word      = (a_wr == 2'b01) || (a_re == 3'b001);
        is_half      = (a_wr == 2'b10) || (a_re == 3'b010) || (a_re == 3'b011);
        // The explicit lower-bound test keeps a wrapped offset from aliasing
        out_of_range = (a_addr < BASE_ADDR) || (offset >= SPAN);
        acc_err      = ((a_wr != 2'b00) && (a_re != 3'b000))
                     || (a_re == 3'b110) || (a_re == 3'b111)
                     || (is_half && a_addr[0])
                     || (is_word && (a_addr[1:0] != 2'b00))
                     || out_of_range;
    end

    // Store lane enables, with the store data replicated across lanes
    logic [3:0]  be;
    logic [31:0] wdata;

    always_comb begin
        be    = 4'b0000;
        wdata = a_din;
        case (a_wr)
            2'b01: begin
                be    = 4'b1111;
                wdata = a_din;
            end
            2'b10: begin
                be    = a_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{a_din[15:0]}};
            end
            2'b11: begin
                be    = 4'b0001 << a_addr[1:0];
                wdata = {4{a_din[7:0]}};
            end
            default: begin
                be    = 4'b0000;
                wdata = a_din;
            end
        endcase
    end

    // Load lane selection and extension
    logic [31:0] rword;
    logic [15:0] rhalf;
    logic [7:0]  rbyte;
    logic [31:0] load_data;

    always_comb begin
        rword = mem[idx];
        rhalf = a_addr[1] ? rword[31:16] : rword[15:0];
        case (a_addr[1:0])
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        case (a_re)
            3'b001:  load_data = rword;
            3'b010:  load_data = {{16{rhalf[15]}}, rhalf};
            3'b011:  load_data = {16'h0000, rhalf};
            3'b100:  load_data = {{24{rbyte[7]}}, rbyte};
            3'b101:  load_data = {24'h000000, rbyte};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // The response edge: the one that moves the FSM into RESP
    logic enter_resp;
    logic do_write;

    always_comb begin
        enter_resp = ((state == IDLE) && req && (WAIT_CYCLES == 0))
                   || ((state == WAIT) && (cnt == 4'd0));
        do_write   = enter_resp && !rst && !acc_err;
    end

    // Array is not reset; only enabled lanes are written
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ready    <= 1'b1;
            ack      <= 1'b0;
            DataOut  <= 32'h0000_0000;
            err      <= 1'b0;
            cap_wr   <= 2'b00;
            cap_re   <= 3'b000;
            cap_addr <= 32'h0000_0000;
            cap_din  <= 32'h0000_0000;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_wr   <= DMWr;
                        cap_re   <= DMRe;
                        cap_addr <= Addr;
                        cap_din  <= DataIn;
                        ready    <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state   <= RESP;
                            ack     <= 1'b1;
                            err     <= acc_err;
                            DataOut <= acc_err ? 32'h0000_0000 : load_data;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state   <= RESP;
                        ack     <= 1'b1;
                        err     <= acc_err;
                        DataOut <= acc_err ? 32'h0000_0000 : load_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - self-checking bench for dm_responder at 0, 2 and 15 wait states

module tb_dm_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_v   [3];
    logic [1:0]  wr_v    [3];
    logic [2:0]  re_v    [3];
    logic [31:0] addr_v  [3];
    logic [31:0] din_v   [3];
    logic        ready_v [3];
    logic        ack_v   [3];
    logic        err_v   [3];
    logic [31:0] dout_v  [3];

    int wc [3] = '{0, 2, 15};

    dm_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req(req_v[0]), .DMWr(wr_v[0]), .DMRe(re_v[0]),
        .Addr(addr_v[0]), .DataIn(din_v[0]), .ready(ready_v[0]), .ack(ack_v[0]),
        .DataOut(dout_v[0]), .err(err_v[0]));

    dm_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .req(req_v[1]), .DMWr(wr_v[1]), .DMRe(re_v[1]),
        .Addr(addr_v[1]), .DataIn(din_v[1]), .ready(ready_v[1]), .ack(ack_v[1]),
        .DataOut(dout_v[1]), .err(err_v[1]));

    dm_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst(rst), .req(req_v[2]), .DMWr(wr_v[2]), .DMRe(re_v[2]),
        .Addr(addr_v[2]), .DataIn(din_v[2]), .ready(ready_v[2]), .ack(ack_v[2]),
        .DataOut(dout_v[2]), .err(err_v[2]));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-addressed reference memory, one per instance
    logic [7:0]  mm       [3][4096];
    logic        pv       [3];
    int          due      [3];
    logic [1:0]  p_wr     [3];
    logic [2:0]  p_re     [3];
    logic [31:0] p_addr   [3];
    logic [31:0] p_din    [3];
    logic [31:0] exp_dout [3];
    int          ncyc  = 0;
    logic        armed = 1'b0;

    function automatic logic model_err(input logic [1:0] w, input logic [2:0] r, input logic [31:0] a);
        longint off;
        off = longint'({32'h0, a});
        return ((w != 2'd0) && (r != 3'd0)) || (r >= 3'd6)
            || (((w == 2'd2) || (r == 3'd2) || (r == 3'd3)) && (a % 2 != 0))
            || (((w == 2'd1) || (r == 3'd1)) && (a % 4 != 0))
            || (off < 0) || (off >= 4 * DEPTH);
    endfunction

    task automatic model_exec(input int i, output logic [31:0] d, output logic e);
        int a;
        logic [15:0] h;
        logic [7:0]  b;
        a = int'(p_addr[i]);
        e = model_err(p_wr[i], p_re[i], p_addr[i]);
        d = 32'h0;
        if (!e) begin
            case (p_wr[i])
                2'd1: for (int k = 0; k < 4; k++) mm[i][a+k] = p_din[i][8*k +: 8];
                2'd2: for (int k = 0; k < 2; k++) mm[i][a+k] = p_din[i][8*k +: 8];
                2'd3: mm[i][a] = p_din[i][7:0];
                default: ;
            endcase
            h = {mm[i][(a+1) % 4096], mm[i][a]};
            b = mm[i][a];
            case (p_re[i])
                3'd1: d = {mm[i][a+3], mm[i][a+2], mm[i][a+1], mm[i][a]};
                3'd2: d = 32'($signed(h));
                3'd3: d = 32'(h);
                3'd4: d = 32'($signed(b));
                3'd5: d = 32'(b);
                default: d = 32'h0;
            endcase
        end
    endtask

    // Compare process: every cycle, all three instances against the model
    always @(negedge clk) begin
        logic        busy;
        logic        exp_ack;
        logic [31:0] d;
        logic        e;
        ncyc++;
        for (int i = 0; i < 3; i++) begin
            busy    = pv[i];
            exp_ack = pv[i] && (ncyc == due[i]);
            if (armed) begin
                chk($sformatf("ready[%0d]@%0d", i, ncyc), 32'(ready_v[i]), 32'(!busy));
                chk($sformatf("ack[%0d]@%0d", i, ncyc), 32'(ack_v[i]), 32'(exp_ack));
                if (exp_ack) begin
                    model_exec(i, d, e);
                    exp_dout[i] = d;
                    chk($sformatf("err[%0d]@%0d", i, ncyc), 32'(err_v[i]), 32'(e));
                    pv[i] = 1'b0;
                end
                chk($sformatf("dout[%0d]@%0d", i, ncyc), dout_v[i], exp_dout[i]);
            end
            if (rst) begin
                pv[i]       = 1'b0;
                exp_dout[i] = 32'h0;
            end else if (armed && !busy && req_v[i]) begin
                pv[i]     = 1'b1;
                due[i]    = ncyc + wc[i] + 1;
                p_wr[i]   = wr_v[i];
                p_re[i]   = re_v[i];
                p_addr[i] = addr_v[i];
                p_din[i]  = din_v[i];
            end
        end
        if (rst) armed = 1'b1;
    end

    // Driver phase is posedge+1; returns the response and the latency in cycles
    task automatic do_acc(input int i, input logic [1:0] w, input logic [2:0] r,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] dout, output logic e, output int lat);
        bit acc = 0;
        bit got = 0;
        int n = 0;
        req_v[i] = 1'b1; wr_v[i] = w; re_v[i] = r; addr_v[i] = a; din_v[i] = d;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = ready_v[i];
            @(posedge clk); #1;
            n++;
        end
        // Inputs after acceptance must not matter
        req_v[i]  = 1'b0;
        wr_v[i]   = 2'($urandom);
        re_v[i]   = 3'($urandom);
        addr_v[i] = $urandom;
        din_v[i]  = $urandom;
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        lat = 0; dout = 32'h0; e = 1'b0;
        while (acc && !got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack_v[i]) begin
                got = 1; dout = dout_v[i]; e = err_v[i];
            end
            @(posedge clk); #1;
        end
        if (acc && !got) chk("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic acc_chk(input string name, input int i, input logic [1:0] w, input logic [2:0] r,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] dout;
        logic        e;
        int          lat;
        do_acc(i, w, r, a, d, dout, e, lat);
        chk({name, "_data"}, dout, exp_d);
        chk({name, "_err"}, 32'(e), 32'(exp_e));
        chk({name, "_lat"}, 32'(lat), 32'(wc[i] + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_k [$];
        int ack_seen;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4096; j++) mm[i][j] = 8'h00;
            pv[i] = 1'b0; exp_dout[i] = 32'h0; due[i] = 0;
            req_v[i] = 1'b0; wr_v[i] = 2'd0; re_v[i] = 3'd0; addr_v[i] = 32'h0; din_v[i] = 32'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(ready_v[1]), 32'd1);
        chk("reset_ack", 32'(ack_v[1]), 32'd0);
        chk("reset_dout", dout_v[1], 32'h0);
        chk("reset_err", 32'(err_v[1]), 32'd0);
        @(posedge clk); #1;

        // Basic store/load, 2 wait states
        acc_chk("sw10", 1, 2'd1, 3'd0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        acc_chk("lw10", 1, 2'd0, 3'd1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Lane writes
        acc_chk("sw20", 1, 2'd1, 3'd0, 32'h20, 32'h11223344, 32'h0, 1'b0);
        acc_chk("sb21", 1, 2'd3, 3'd0, 32'h21, 32'hFFFFFFAA, 32'h0, 1'b0);
        acc_chk("lw20a", 1, 2'd0, 3'd1, 32'h20, 32'h0, 32'h1122AA44, 1'b0);
        acc_chk("sh22", 1, 2'd2, 3'd0, 32'h22, 32'h55558001, 32'h0, 1'b0);
        acc_chk("lw20b", 1, 2'd0, 3'd1, 32'h20, 32'h0, 32'h8001AA44, 1'b0);

        // Extension
        acc_chk("lb21", 1, 2'd0, 3'd4, 32'h21, 32'h0, 32'hFFFFFFAA, 1'b0);
        acc_chk("lbu21", 1, 2'd0, 3'd5, 32'h21, 32'h0, 32'h000000AA, 1'b0);
        acc_chk("lh22", 1, 2'd0, 3'd2, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
        acc_chk("lhu22", 1, 2'd0, 3'd3, 32'h22, 32'h0, 32'h00008001, 1'b0);
        acc_chk("lb20", 1, 2'd0, 3'd4, 32'h20, 32'h0, 32'h00000044, 1'b0);

        // Errors never write and return zero
        acc_chk("sw30", 1, 2'd1, 3'd0, 32'h30, 32'h0, 32'h0, 1'b0);
        acc_chk("e_sw32", 1, 2'd1, 3'd0, 32'h32, 32'h12345678, 32'h0, 1'b1);
        acc_chk("e_lh31", 1, 2'd0, 3'd2, 32'h31, 32'h0, 32'h0, 1'b1);
        acc_chk("e_range", 1, 2'd1, 3'd0, 32'(4 * DEPTH), 32'h1, 32'h0, 1'b1);
        acc_chk("e_huge", 1, 2'd3, 3'd0, 32'hFFFFFFF0, 32'h1, 32'h0, 1'b1);
        acc_chk("e_both", 1, 2'd1, 3'd1, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1);
        acc_chk("e_re7", 1, 2'd0, 3'd7, 32'h30, 32'h0, 32'h0, 1'b1);
        acc_chk("e_sh31", 1, 2'd2, 3'd0, 32'h31, 32'hFFFF, 32'h0, 1'b1);
        acc_chk("lw30", 1, 2'd0, 3'd1, 32'h30, 32'h0, 32'h0, 1'b0);
        acc_chk("noop", 1, 2'd0, 3'd0, 32'h30, 32'h0, 32'h0, 1'b0);

        // Last word in range
        acc_chk("sw_last", 1, 2'd1, 3'd0, 32'(4 * DEPTH - 4), 32'hA5A55A5A, 32'h0, 1'b0);
        acc_chk("lb_last", 1, 2'd0, 3'd4, 32'(4 * DEPTH - 1), 32'h0, 32'hFFFFFFA5, 1'b0);

        // Reset during the wait state aborts the store
        acc_chk("sw40", 1, 2'd1, 3'd0, 32'h40, 32'h0, 32'h0, 1'b0);
        req_v[1] = 1'b1; wr_v[1] = 2'd1; re_v[1] = 3'd0; addr_v[1] = 32'h40; din_v[1] = 32'h55;
        @(negedge clk);
        chk("abort_accept", 32'(ready_v[1]), 32'd1);
        @(posedge clk); #1;
        req_v[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ack_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack_v[1]) ack_seen++;
            @(posedge clk); #1;
        end
        chk("abort_no_ack", 32'(ack_seen), 32'd0);
        acc_chk("lw40", 1, 2'd0, 3'd1, 32'h40, 32'h0, 32'h0, 1'b0);

        // Zero wait states
        acc_chk("w0_sw", 0, 2'd1, 3'd0, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
        acc_chk("w0_lw", 0, 2'd0, 3'd1, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
        acc_chk("w0_lhu", 0, 2'd0, 3'd3, 32'h12, 32'h0, 32'h0000CAFE, 1'b0);

        // req held high: one accept every 2 cycles
        req_v[0] = 1'b1; wr_v[0] = 2'd1; re_v[0] = 3'd0; addr_v[0] = 32'h50;
        for (int k = 0; k < 12; k++) begin
            din_v[0] = 32'h1000 + 32'(k);
            @(negedge clk);
            if (ready_v[0]) acc_k.push_back(k);
            @(posedge clk); #1;
        end
        req_v[0] = 1'b0;
        chk("b2b_count", 32'(acc_k.size()), 32'd6);
        for (int j = 0; j < acc_k.size(); j++)
            chk($sformatf("b2b_slot%0d", j), 32'(acc_k[j]), 32'(2 * j));
        acc_chk("w0_lw50", 0, 2'd0, 3'd1, 32'h50, 32'h0, 32'h0000100A, 1'b0);

        // Fifteen wait states
        acc_chk("w15_sw", 2, 2'd1, 3'd0, 32'h10, 32'h0BADF00D, 32'h0, 1'b0);
        acc_chk("w15_lb", 2, 2'd0, 3'd4, 32'h11, 32'h0, 32'hFFFFFFF0, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
